ex_div_unit: RTL and testbench
==============================

// Module: ex_div_unit
// PURPOSE
//  Multi-cycle iterative integer divider in the EX stage. Produces the ex_ok
//  signal consumed by the stall/flush controller: ok_o low = "EX not finished",
//  which stalls IF..MEM/WB. Radix-2 restoring divider, one quotient bit/cycle.
//  Implements DIV/DIVU for HI/LO. Cancelled by the exception flush.
// PARAMETERS
//  WIDTH  32  operand/result width in bits (counter sized clog2(WIDTH)+1)
// PORTS
//  clk_i        in   1      clock, all state on rising edge
//  rst_n_i      in   1      asynchronous, active-low reset
//  start_i      in   1      DIV/DIVU instruction present in EX; held high while stalled
//  signed_i     in   1      1 = DIV (two's complement), 0 = DIVU; sampled with start
//  dividend_i   in   WIDTH  rs operand; sampled with start
//  divisor_i    in   WIDTH  rt operand; sampled with start
//  flush_i      in   1      exception flush from stall/flush controller
//  ok_o         out  1      EX complete (to ex_ok_i); combinational
//  busy_o       out  1      state == DIV (registered)
//  quotient_o   out  WIDTH  quotient (to LO), registered
//  remainder_o  out  WIDTH  remainder (to HI), registered
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, quotient_o=0, remainder_o=0, busy_o=0; ok_o=1.
//  States: IDLE, DIV, DONE.
//  - IDLE: start_i & ~flush_i -> latch |dividend|, |divisor|, sign bits,
//    cnt=0. divisor==0 -> DONE directly; else -> DIV. Else stay IDLE.
//  - DIV: each cycle shift {rem,quo} left 1, trial-subtract divisor, set quo
//    LSB if non-negative; cnt++. After WIDTH iterations -> DONE, and
//    quotient_o/remainder_o load sign-corrected results on that same edge.
//  - DONE: unconditional -> IDLE (pipeline advances this cycle). A new start
//    is only accepted from IDLE, so the finished instruction never restarts.
//  ok_o = (state==DONE) | (state==IDLE & ~start_i) | flush_i; 0 in DIV and in
//    IDLE with start_i. Start at edge E0: ok_o low in start cycle and in
//    WIDTH DIV cycles, high in DONE cycle; total stall = WIDTH+1 cycles.
//  Signed: magnitudes divided unsigned; quotient negated if sign(a)^sign(b);
//    remainder negated if sign(a) (remainder takes dividend sign).
//    0x80000000 / 0xFFFFFFFF (signed) -> q=0x80000000, r=0 (wraps, no trap).
//  Divide by zero (either mode): 1-cycle path, q=all ones, r=dividend_i raw.
//  Results hold from DONE until the next DONE; flush never alters them.
//  flush_i (sync): any state -> IDLE next edge, cnt=0, partial work dropped,
//    outputs not updated; flush with start_i in IDLE does not start.
//  Async reset mid-DIV: immediate return to reset values; no result written.
//  Operand changes on dividend_i/divisor_i after start are ignored.
// TESTING
//  1. DIVU 100/7 -> ok_o low 33 cycles from start, then 1 cycle high;
//     q=14, r=2; busy_o high exactly 32 cycles.
//  2. DIV -7/2 (0xFFFFFFF9,2) -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1);
//     DIV 7/-2 -> q=-3, r=1.
//  3. DIV 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0; DIVU same -> q=0, r=0x80000000.
//  4. DIVU 5/0 -> ok_o low 1 cycle only, q=0xFFFFFFFF, r=5.
//  5. flush_i at iteration 10 -> IDLE next cycle, ok_o=1, q/r keep prior
//     values; later DIVU 9/3 -> q=3, r=0 with full 33-cycle stall.
//  6. Back-to-back DIVU 20/3 then 21/4 (start_i held across DONE) -> second
//     starts in IDLE after DONE; results 6/2 then 5/1; rst_n_i low mid-DIV ->
//     all outputs 0, ok_o=1 immediately.

Source files
------------

// File: rtl/ex_div_unit_if.sv
// Handshake and data bundle between the EX stage and the iterative divider.
// The divider side uses the slave modport; the stage/testbench side uses master.
interface ex_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic             signed_i;
    logic [WIDTH-1:0] dividend_i;
    logic [WIDTH-1:0] divisor_i;
    logic             flush_i;
    logic             ok_o;
    logic             busy_o;
    logic [WIDTH-1:0] quotient_o;
    logic [WIDTH-1:0] remainder_o;

    modport master (
        output start_i, signed_i, dividend_i, divisor_i, flush_i,
        input  ok_o, busy_o, quotient_o, remainder_o
    );

    modport slave (
        input  start_i, signed_i, dividend_i, divisor_i, flush_i,
        output ok_o, busy_o, quotient_o, remainder_o
    );
endinterface

// File: rtl/ex_div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle on operand
// magnitudes, sign-corrected into registered HI/LO results; ok_o drives EX stall.
module ex_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    ex_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem, r_quo, r_dvs;
    logic [WIDTH-1:0] r_quotient, r_remainder;
    logic             r_neg_q, r_neg_r;

    logic             w_start, w_div0, w_a_neg, w_b_neg, w_ge, w_last;
    logic [WIDTH-1:0] w_a_abs, w_b_abs, w_sub, w_rem_nx, w_quo_nx;
    logic [WIDTH:0]   w_rem_sh;

    assign w_start  = bus.start_i & ~bus.flush_i;
    assign w_div0   = (bus.divisor_i == '0);
    assign w_a_neg  = bus.signed_i & bus.dividend_i[WIDTH-1];
    assign w_b_neg  = bus.signed_i & bus.divisor_i[WIDTH-1];
    assign w_a_abs  = w_a_neg ? ('0 - bus.dividend_i) : bus.dividend_i;
    assign w_b_abs  = w_b_neg ? ('0 - bus.divisor_i)  : bus.divisor_i;

    // Partial remainder needs one extra bit after the shift; the difference
    // always fits in WIDTH bits whenever it is kept.
    assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_dvs});
    assign w_sub    = w_rem_sh[WIDTH-1:0] - r_dvs;
    assign w_rem_nx = w_ge ? w_sub : w_rem_sh[WIDTH-1:0];
    assign w_quo_nx = {r_quo[WIDTH-2:0], w_ge};
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = w_div0 ? S_DONE : S_DIV;
            S_DIV:   if (w_last)  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (bus.flush_i) w_next = S_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else if (bus.flush_i) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_start) begin
                    r_rem   <= '0;
                    r_quo   <= w_a_abs;
                    r_dvs   <= w_b_abs;
                    r_neg_q <= w_a_neg ^ w_b_neg;
                    r_neg_r <= w_a_neg;
                    r_cnt   <= '0;
                    // Divide by zero bypasses iteration with fixed MIPS-style results.
                    if (w_div0) begin
                        r_quotient  <= '1;
                        r_remainder <= bus.dividend_i;
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_nx;
                    r_quo <= w_quo_nx;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_quotient  <= r_neg_q ? ('0 - w_quo_nx) : w_quo_nx;
                        r_remainder <= r_neg_r ? ('0 - w_rem_nx) : w_rem_nx;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ok_o        = (r_state == S_DONE) | ((r_state == S_IDLE) & ~bus.start_i) | bus.flush_i;
    assign bus.busy_o      = (r_state == S_DIV);
    assign bus.quotient_o  = r_quotient;
    assign bus.remainder_o = r_remainder;
endmodule

// File: tb/tb_ex_div_unit.sv
// Randomized and directed check of ex_div_unit against an arithmetic reference
// model: results, stall length, busy duration, flush and reset behaviour.
module tb_ex_div_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    logic [W-1:0] exp_q, exp_r;

    ex_div_unit_if #(.WIDTH(W)) bus ();

    ex_div_unit #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: truncating division, remainder follows the dividend sign,
    // divide by zero gives all ones / raw dividend.
    task automatic model(input bit sg, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa, sb, tq, tr;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            tq = sa / sb;
            tr = sa % sb;
            q  = tq[W-1:0];
            r  = tr[W-1:0];
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // chained: previous call left start_i high at its DONE cycle.
    task automatic run_div(input string tag, input bit sg, input logic [W-1:0] a,
                           input logic [W-1:0] b, input bit chained, input bit keep);
        int lows = 0;
        int busys = 0;
        bit done = 1'b0;
        if (!chained) @(negedge clk);
        bus.start_i    = 1'b1;
        bus.flush_i    = 1'b0;
        bus.signed_i   = sg;
        bus.dividend_i = a;
        bus.divisor_i  = b;
        model(sg, a, b, exp_q, exp_r);
        if (chained) @(negedge clk);
        #1;
        for (int i = 0; i < 100; i++) begin
            if (bus.ok_o) begin
                done = 1'b1;
                break;
            end
            lows++;
            if (bus.busy_o) busys++;
            @(negedge clk);
            if (i == 0) begin
                bus.dividend_i = $urandom;
                bus.divisor_i  = $urandom;
                bus.signed_i   = $urandom_range(0, 1);
            end
            #1;
        end
        chk({tag, "_done"}, 64'(done), 64'(1));
        chk({tag, "_stall"}, 64'(lows), (b == '0) ? 64'(1) : 64'(W + 1));
        chk({tag, "_busy"}, 64'(busys), (b == '0) ? 64'(0) : 64'(W));
        chk({tag, "_q"}, 64'(bus.quotient_o), 64'(exp_q));
        chk({tag, "_r"}, 64'(bus.remainder_o), 64'(exp_r));
        if (!keep) bus.start_i = 1'b0;
    endtask

    initial begin
        logic [W-1:0] a, b;
        bit sg;
        bus.start_i    = 1'b0;
        bus.flush_i    = 1'b0;
        bus.signed_i   = 1'b0;
        bus.dividend_i = '0;
        bus.divisor_i  = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ok", 64'(bus.ok_o), 64'(1));
        chk("rst_busy", 64'(bus.busy_o), 64'(0));
        chk("rst_q", 64'(bus.quotient_o), 64'(0));
        chk("rst_r", 64'(bus.remainder_o), 64'(0));
        rst_n = 1'b1;

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 1'b0, 1'b0);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_div("divu_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 1'b0, 1'b0);
        run_div("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 1'b0, 1'b0);

        // Flush at iteration 10: prior results must survive.
        @(negedge clk);
        bus.start_i = 1'b1; bus.signed_i = 1'b0;
        bus.dividend_i = 32'd1000; bus.divisor_i = 32'd9;
        repeat (11) @(negedge clk);
        bus.flush_i = 1'b1; bus.start_i = 1'b0;
        #1;
        chk("flush_ok", 64'(bus.ok_o), 64'(1));
        @(negedge clk);
        bus.flush_i = 1'b0;
        #1;
        chk("flush_idle_ok", 64'(bus.ok_o), 64'(1));
        chk("flush_busy", 64'(bus.busy_o), 64'(0));
        chk("flush_q", 64'(bus.quotient_o), 64'(exp_q));
        chk("flush_r", 64'(bus.remainder_o), 64'(exp_r));
        // Flush together with start in IDLE must not launch a divide.
        @(negedge clk);
        bus.flush_i = 1'b1; bus.start_i = 1'b1;
        bus.dividend_i = 32'd50; bus.divisor_i = 32'd4;
        @(negedge clk);
        bus.flush_i = 1'b0; bus.start_i = 1'b0;
        #1;
        chk("flush_start_busy", 64'(bus.busy_o), 64'(0));
        chk("flush_start_q", 64'(bus.quotient_o), 64'(exp_q));
        run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 1'b0, 1'b0);

        // Back-to-back with start held across DONE.
        run_div("b2b_20_3", 1'b0, 32'd20, 32'd3, 1'b0, 1'b1);
        run_div("b2b_21_4", 1'b0, 32'd21, 32'd4, 1'b1, 1'b0);

        for (int k = 0; k < 25; k++) begin
            sg = 1'($urandom_range(0, 1));
            a  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = '1;
                3:       begin a = 32'h8000_0000; b = $urandom; end
                default: b = $urandom;
            endcase
            run_div($sformatf("rnd%0d", k), sg, a, b, 1'b0, 1'b0);
        end

        // Async reset in the middle of a divide.
        @(negedge clk);
        bus.start_i = 1'b1; bus.signed_i = 1'b1;
        bus.dividend_i = 32'hFFFF_0000; bus.divisor_i = 32'd3;
        repeat (6) @(negedge clk);
        rst_n = 1'b0; bus.start_i = 1'b0;
        #1;
        chk("arst_ok", 64'(bus.ok_o), 64'(1));
        chk("arst_busy", 64'(bus.busy_o), 64'(0));
        chk("arst_q", 64'(bus.quotient_o), 64'(0));
        chk("arst_r", 64'(bus.remainder_o), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_div("post_rst", 1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
